cam_capture_fmt: RTL
====================

Name: cam_capture_fmt

Overview:
- Parametrised successor to the fixed-format OV7670 pixel capture stage; runs entirely in the camera pixel clock domain.
- Assembles byte pairs into pixels in one of three selectable formats (RGB444, RGB565, Y-only).
- Applies optional power-of-two decimation, then writes frame-buffer BRAM at a linear address.
- Supports continuous or single-shot capture and reports frame completion, a frame count and sticky geometry errors to system control.

Parameters:
- H_RES, 640, active pixels per line delivered by the sensor.
- V_RES, 480, active lines per frame.
- DECIM, 1, subsampling factor in both axes; legal values 1, 2, 4.
- ADDR_W, 19, width of o_pix_addr; must hold (H_RES/DECIM)*(V_RES/DECIM)-1.
- FCNT_W, 8, width of the frame counter.

Ports:
- i_pclk  in  1  sensor pixel clock; the only clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_cam_done  in  1  sensor register configuration complete; capture is held off until high.
- i_fmt  in  2  pixel format: 0 RGB444, 1 RGB565, 2 Y-only (YUYV); 3 is treated as 0.
- i_single  in  1  1 = single-shot mode, 0 = continuous mode.
- i_arm  in  1  one-cycle pulse; starts one capture in single-shot mode, or re-arms from DONE.
- i_vsync  in  1  sensor VSYNC, active high during vertical blanking.
- i_href  in  1  sensor HREF, high while line bytes are valid.
- i_D  in  8  sensor data byte.
- o_wren  out  1  BRAM write enable, one cycle per stored pixel.
- o_pix_addr  out  ADDR_W  BRAM write address.
- o_pix_data  out  16  pixel word, LSB-aligned, unused MSBs zero.
- o_frame_done  out  1  one-cycle pulse at end of a captured frame.
- o_frame_cnt  out  FCNT_W  count of completed frames; wraps.
- o_busy  out  1  high in SYNC and CAPTURE states.
- o_err  out  2  sticky flags: [0] long line or extra lines, [1] short line or odd byte count.

Behaviour:
- Inputs are sampled on the rising edge of i_pclk. Edges of i_vsync and i_href are detected against a one-cycle registered copy of each.
- Reset value of all outputs is 0. Internal state after reset: FSM in IDLE, all counters cleared.
- FSM states:
  - IDLE: wait for i_cam_done=1. In continuous mode, go to SYNC. In single-shot mode, wait in IDLE for i_arm, then go to SYNC.
  - SYNC: wait for a falling edge of i_vsync (start of frame). On it, clear the address, column, row and byte-phase counters and go to CAPTURE.
  - CAPTURE: assemble and write pixels. On a rising edge of i_vsync, pulse o_frame_done, increment o_frame_cnt, then go to SYNC in continuous mode or DONE in single-shot mode.
  - DONE: hold, with o_wren=0. i_arm moves to SYNC. Clearing i_single moves to SYNC.
- If i_cam_done falls in any state, the FSM returns to IDLE next cycle with no frame_done pulse.
- Byte phase:
  - Toggles on each cycle with i_href=1; reset to 0 whenever i_href=0.
  - Phase 0 byte is latched; the pixel is formed when the phase 1 byte arrives.
  - Odd number of bytes at the i_href falling edge: the trailing byte is discarded and o_err[1] is set.
- Pixel formation (b0 = first byte, b1 = second byte):
  - Format 0: {b0[3:0], b1[7:0]}, 12 bits.
  - Format 1: {b0, b1}, 16 bits.
  - Format 2: b0 (Y), 8 bits.
- Column counter increments per pixel. Row counter increments on each falling edge of i_href.
- A pixel is stored only if col%DECIM==0, row%DECIM==0, col<H_RES and row<V_RES.
- Stored pixels: o_wren=1 and o_pix_data valid in the cycle after the phase 1 byte is sampled (1-cycle latency). o_pix_addr holds the address for that write; it increments by 1 after each write and starts at 0 each frame.
- Range violations:
  - Any pixel with col>=H_RES, or any line with row>=V_RES, is dropped and sets o_err[0].
  - A line ending with col<H_RES sets o_err[1].
- o_err is cleared by reset and by i_arm only.
- i_fmt is sampled at the SYNC-to-CAPTURE transition and held for the whole frame. i_single is read live.
- A frame that ends (i_vsync rising edge) before any line arrived still pulses o_frame_done.
- o_frame_cnt wraps from 2^FCNT_W-1 to 0.

Test Plan:
- Reset, continuous mode, i_fmt=0, 4x2 frame (H_RES=4, V_RES=2), b0=0x0A, b1=0xBC -> 8 writes, addresses 0..7, o_pix_data=0x0ABC, one o_frame_done pulse, o_frame_cnt=1, o_err=0.
- i_fmt=1, single-shot mode, i_arm pulse, two frames sent -> first frame written with o_pix_data=0xABBC from bytes 0xAB, 0xBC; FSM reaches DONE; second frame produces no o_wren; o_frame_cnt=1.
- DECIM=2, H_RES=8, V_RES=4 -> exactly 8 writes (addresses 0..7), taken from even columns of rows 0 and 2.
- Line of 9 bytes followed by a line of 10 pixels (H_RES=8) -> o_err=2'b11, exactly 8 pixels stored for the long line, next frame starts again at address 0.
- i_cam_done deasserted mid-frame -> o_wren=0 from the next cycle, o_busy=0, no o_frame_done pulse; when i_cam_done is reasserted, capture restarts at address 0 on the next i_vsync falling edge.
- i_rstn asserted asynchronously mid-line -> all outputs 0 immediately; o_frame_cnt=0.

Source files
------------

// File: rtl/cam_capture_fmt.sv
// Camera pixel capture: pairs sensor bytes into RGB444/RGB565/Y pixels, decimates,
// and writes them to a frame buffer at a linear address, with frame and error status.
module cam_capture_fmt #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int DECIM  = 1,
    parameter int ADDR_W = 19,
    parameter int FCNT_W = 8
) (
    input  logic              i_pclk,
    input  logic              i_rstn,
    input  logic              i_cam_done,
    input  logic [1:0]        i_fmt,
    input  logic              i_single,
    input  logic              i_arm,
    input  logic              i_vsync,
    input  logic              i_href,
    input  logic [7:0]        i_D,
    output logic              o_wren,
    output logic [ADDR_W-1:0] o_pix_addr,
    output logic [15:0]       o_pix_data,
    output logic              o_frame_done,
    output logic [FCNT_W-1:0] o_frame_cnt,
    output logic              o_busy,
    output logic [1:0]        o_err
);
    localparam int COL_W = $clog2(H_RES + 1);
    localparam int ROW_W = $clog2(V_RES + 1);
    localparam logic [COL_W-1:0] H_LIM  = COL_W'(H_RES);
    localparam logic [ROW_W-1:0] V_LIM  = ROW_W'(V_RES);
    localparam logic [COL_W-1:0] C_MASK = COL_W'(DECIM - 1);
    localparam logic [ROW_W-1:0] R_MASK = ROW_W'(DECIM - 1);

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_CAPTURE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              vsync_q, vsync_d, href_q, href_d, phase_q, phase_d;
    logic [7:0]        b0_q, b0_d;
    logic [1:0]        fmt_q, fmt_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d, pix_addr_q, pix_addr_d;
    logic              wren_q, wren_d, frame_done_q, frame_done_d, busy_q, busy_d;
    logic [15:0]       pix_data_q, pix_data_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [1:0]        err_q, err_d;

    logic              vsync_rise, vsync_fall, href_fall, in_range;
    logic [15:0]       pix;

    assign vsync_rise = i_vsync & ~vsync_q;
    assign vsync_fall = ~i_vsync & vsync_q;
    assign href_fall  = ~i_href & href_q;
    assign in_range   = (col_q < H_LIM) && (row_q < V_LIM);

    always_comb begin
        case (fmt_q)
            2'd1:    pix = {b0_q, i_D};
            2'd2:    pix = {8'h00, b0_q};
            default: pix = {4'h0, b0_q[3:0], i_D};
        endcase
    end

    always_comb begin
        state_d      = state_q;
        vsync_d      = i_vsync;
        href_d       = i_href;
        phase_d      = i_href ? ~phase_q : 1'b0;
        b0_d         = b0_q;
        fmt_d        = fmt_q;
        col_d        = col_q;
        row_d        = row_q;
        addr_cnt_d   = addr_cnt_q;
        pix_addr_d   = pix_addr_q;
        pix_data_d   = pix_data_q;
        wren_d       = 1'b0;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        err_d        = i_arm ? 2'b00 : err_q;

        if (!i_cam_done) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (!i_single || i_arm) state_d = S_SYNC;
                S_SYNC: begin
                    if (vsync_fall) begin
                        addr_cnt_d = '0;
                        pix_addr_d = '0;
                        col_d      = '0;
                        row_d      = '0;
                        phase_d    = 1'b0;
                        fmt_d      = (i_fmt == 2'd3) ? 2'd0 : i_fmt;
                        state_d    = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (i_href && !phase_q) b0_d = i_D;
                    // Second byte of a pair completes a pixel; only in-range, on-grid pixels are written.
                    if (i_href && phase_q) begin
                        if (in_range && ((col_q & C_MASK) == '0) && ((row_q & R_MASK) == '0)) begin
                            wren_d     = 1'b1;
                            pix_addr_d = addr_cnt_q;
                            addr_cnt_d = addr_cnt_q + ADDR_W'(1);
                            pix_data_d = pix;
                        end
                        if (!in_range) err_d[0] = 1'b1;
                        if (col_q < H_LIM) col_d = col_q + COL_W'(1);
                    end
                    // Counters saturate at the limit so out-of-range lines/pixels stay flagged.
                    if (href_fall) begin
                        if (phase_q || (col_q < H_LIM)) err_d[1] = 1'b1;
                        col_d = '0;
                        if (row_q < V_LIM) row_d = row_q + ROW_W'(1);
                    end
                    if (vsync_rise) begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + FCNT_W'(1);
                        state_d      = i_single ? S_DONE : S_SYNC;
                    end
                end
                S_DONE: if (i_arm || !i_single) state_d = S_SYNC;
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d == S_SYNC) || (state_d == S_CAPTURE);
    end

    always_ff @(posedge i_pclk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q      <= S_IDLE;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            phase_q      <= 1'b0;
            b0_q         <= '0;
            fmt_q        <= '0;
            col_q        <= '0;
            row_q        <= '0;
            addr_cnt_q   <= '0;
            pix_addr_q   <= '0;
            pix_data_q   <= '0;
            wren_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            busy_q       <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            phase_q      <= phase_d;
            b0_q         <= b0_d;
            fmt_q        <= fmt_d;
            col_q        <= col_d;
            row_q        <= row_d;
            addr_cnt_q   <= addr_cnt_d;
            pix_addr_q   <= pix_addr_d;
            pix_data_q   <= pix_data_d;
            wren_q       <= wren_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign o_wren       = wren_q;
    assign o_pix_addr   = pix_addr_q;
    assign o_pix_data   = pix_data_q;
    assign o_frame_done = frame_done_q;
    assign o_frame_cnt  = frame_cnt_q;
    assign o_busy       = busy_q;
    assign o_err        = err_q;
endmodule
